p_int_acc_stream: RTL and testbench
===================================

P_INT_ACC_STREAM -- requirements
Module: p_int_acc_stream

Interface -- parameters
REQ-001 SHALL have parameter IN, default 8: lanes per input beat, IN >= 1, need not be a power of two.
REQ-002 SHALL have parameter PREC, default 8: element and result width in bits.
REQ-003 SHALL have parameter SIGN, default 1: 1 = two's-complement signed operands/result, 0 = unsigned.
REQ-004 SHALL have parameter SAT, default 1: 1 = saturate out-of-range result, 0 = wrap (keep low PREC bits).
REQ-005 SHALL have parameter MAXBEAT, default 16: beats per sum covered exactly by the internal accumulator; MAXBEAT >= 1.

Interface -- ports
REQ-006 SHALL have one clock and a synchronous, active-low reset.
REQ-007 clk  in  1  clock; all state updates on its rising edge.
REQ-008 reset_  in  1  synchronous active-low reset.
REQ-009 in_valid  in  1  input beat valid.
REQ-010 in_ready  out  1  block accepts a beat.
REQ-011 in_data  in  [IN-1:0][PREC-1:0]  lane elements.
REQ-012 in_keep  in  IN  per-lane enable; a 0 lane contributes zero.
REQ-013 in_last  in  1  final beat of the current sum.
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  consumer accepts the result.
REQ-016 out_data  out  PREC  final sum after saturate or wrap.
REQ-017 out_ovf  out  1  result did not fit in PREC, or more than MAXBEAT beats were summed.

Function
REQ-018 A beat SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-019 Stage 1 SHALL reduce the kept lanes of an accepted beat with a binary adder tree of width PREC+clog2(IN) (sign-extended when SIGN=1, zero-extended otherwise) and register the lane sum.
REQ-020 Stage 2 SHALL add the registered lane sum into a wide accumulator of width PREC+clog2(IN)+clog2(MAXBEAT)+1; no intermediate wrap is permitted.
REQ-021 The FSM SHALL have states ACC, FLUSH and DONE.
REQ-022 ACC: in_ready=1; an accepted beat with in_last=1 moves the FSM to FLUSH.
REQ-023 FLUSH: lasts exactly one cycle with in_ready=0, lets stage 2 absorb the last lane sum, then moves to DONE.
REQ-024 DONE: out_valid=1, in_ready=0; out_data and out_ovf stay stable until out_valid && out_ready.
REQ-025 On the DONE handshake the FSM SHALL clear the accumulator, beat counter and sticky flag and return to ACC, so in_ready=1 on the next cycle.
REQ-026 Latency: out_valid SHALL assert exactly 2 cycles after the edge that accepts the last beat.
REQ-027 Range check: the result SHALL be checked against [-2^(PREC-1), 2^(PREC-1)-1] when SIGN=1 and [0, 2^PREC-1] when SIGN=0.
REQ-028 Out of range: out_ovf=1; out_data = nearest bound when SAT=1, or the low PREC bits of the exact sum when SAT=0.
REQ-029 A beat counter SHALL count accepted beats and saturate at MAXBEAT+1; reaching MAXBEAT+1 sets a sticky overflow, which forces out_ovf=1 for that sum.
REQ-030 A beat with in_keep all-zero SHALL still count as a beat and contribute 0.
REQ-031 in_data and in_keep SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-032 While reset_=0 at a rising edge, the FSM SHALL enter ACC and clear the accumulator, stage-1 register, beat counter and sticky flag.
REQ-033 During reset, out_valid=0, out_data=0, out_ovf=0 and in_ready=0; in_ready=1 on the first cycle after reset_ returns to 1.
REQ-034 Reset asserted mid-sum or in DONE SHALL discard the partial or pending result; no output handshake occurs.

Verification (IN=4, PREC=8, SIGN=1, SAT=1, MAXBEAT=4 unless noted)
REQ-035 One beat {1,2,3,4}, keep=4'hF, last=1 -> out_valid 2 cycles later, out_data=10, out_ovf=0.
REQ-036 Three beats {100,100,0,0}, last on the third -> exact sum 600: SAT=1 gives 127/ovf=1; SAT=0 gives 88 (0x58)/ovf=1.
REQ-037 One beat {-128,-128,0,0}, last -> out_data=-128 (0x80), out_ovf=1.
REQ-038 One beat {10,20,30,40}, keep=4'b0101, last -> out_data=40, out_ovf=0.
REQ-039 Result pending with out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0; handshake -> in_ready=1 next cycle.
REQ-040 Reset pulse after 2 non-last beats {50,0,0,0}, then one beat {5,0,0,0} last -> out_data=5, out_ovf=0.
REQ-041 Five beats {1,0,0,0}, last on the fifth (MAXBEAT=4) -> out_data=5, out_ovf=1.

Source files
------------

// File: rtl/p_int_acc_stream.sv
// p_int_acc_stream: lane-reduce each beat, accumulate beats wide,
// then range-check the sum and hold it until the consumer takes it.
module p_int_acc_stream #(
  parameter int IN      = 8,
  parameter int PREC    = 8,
  parameter int SIGN    = 1,
  parameter int SAT     = 1,
  parameter int MAXBEAT = 16
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN-1:0][PREC-1:0] in_data,
  input  logic [IN-1:0]           in_keep,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PREC-1:0]         out_data,
  output logic                    out_ovf
);
  localparam int LG = $clog2(IN);
  localparam int NP = 1 << LG;
  localparam int LW = PREC + LG;
  localparam int AW = LW + $clog2(MAXBEAT) + 1;
  localparam int CW = $clog2(MAXBEAT + 2);

  localparam longint HI_L = (SIGN != 0)
    ? (longint'(1) << (PREC - 1)) - 1
    : (longint'(1) << PREC) - 1;
  localparam longint LO_L = (SIGN != 0)
    ? -(longint'(1) << (PREC - 1))
    : longint'(0);

  localparam logic signed [AW-1:0] HI = AW'(HI_L);
  localparam logic signed [AW-1:0] LO = AW'(LO_L);
  localparam logic [CW-1:0] CMAX = CW'(MAXBEAT);
  localparam logic [CW-1:0] CTOP = CW'(MAXBEAT + 1);

  typedef enum logic [1:0] {
    ACC,
    FLUSH,
    DONE
  } state_t;

  state_t state;

  logic signed [LW-1:0] lane_sum;
  logic signed [LW-1:0] s1;
  logic                 s1_vld;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] sum;
  logic [CW-1:0]        cnt;
  logic                 sticky;
  logic                 accept;
  logic                 hi;
  logic                 lo;
  logic [PREC-1:0]      res;

  assign in_ready = reset_ & (state == ACC);
  assign accept   = in_valid & in_ready;

  // Heap-ordered tree padded to a power of two; pad leaves stay zero.
  always_comb begin
    logic signed [LW-1:0] t [2*NP-1];
    for (int i = 0; i < 2*NP-1; i++) t[i] = '0;
    for (int i = 0; i < IN; i++) begin
      if (in_keep[i]) begin
        if (SIGN != 0) t[NP-1+i] = LW'($signed(in_data[i]));
        else           t[NP-1+i] = LW'(in_data[i]);
      end
    end
    for (int n = NP-2; n >= 0; n--) begin
      t[n] = t[2*n+1] + t[2*n+2];
    end
    lane_sum = t[0];
  end

  // Unsigned lane sums may use the top bit, so never sign-extend them.
  always_comb begin
    ext = AW'(s1);
    if (SIGN == 0) ext = AW'($unsigned(s1));
    sum = acc + ext;
    hi  = sum > HI;
    lo  = sum < LO;
    res = sum[PREC-1:0];
    if (SAT != 0 && hi) res = HI[PREC-1:0];
    if (SAT != 0 && lo) res = LO[PREC-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state     <= ACC;
      s1        <= '0;
      s1_vld    <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1 <= lane_sum;
        if (cnt != CTOP) cnt <= cnt + 1'b1;
        if (cnt == CMAX) sticky <= 1'b1;
      end
      if (s1_vld) acc <= sum;
      unique case (state)
        ACC: begin
          if (accept && in_last) state <= FLUSH;
        end
        FLUSH: begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_data  <= res;
          out_ovf   <= hi | lo | sticky;
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            sticky    <= 1'b0;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_p_int_acc_stream.sv
// tb_p_int_acc_stream: directed scenarios on a 4-lane signed block,
// one saturating and one wrapping instance fed identically.
module tb_p_int_acc_stream;
  logic             clk;
  logic             reset_;
  logic             in_valid;
  logic [3:0][7:0]  in_data;
  logic [3:0]       in_keep;
  logic             in_last;
  logic             out_ready;

  logic             in_ready0;
  logic             out_valid0;
  logic [7:0]       out_data0;
  logic             out_ovf0;
  logic             in_ready1;
  logic             out_valid1;
  logic [7:0]       out_data1;
  logic             out_ovf1;

  int total;
  int bad;

  p_int_acc_stream #(
    .IN(4), .PREC(8), .SIGN(1), .SAT(1), .MAXBEAT(4)
  ) u_sat (
    .clk(clk), .reset_(reset_),
    .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_ovf(out_ovf0)
  );

  p_int_acc_stream #(
    .IN(4), .PREC(8), .SIGN(1), .SAT(0), .MAXBEAT(4)
  ) u_wrap (
    .clk(clk), .reset_(reset_),
    .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_ovf(out_ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic beat(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3,
                      input logic [3:0] keep, input logic last);
    in_valid = 1'b1;
    in_data  = {d3, d2, d1, d0};
    in_keep  = keep;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_result(output logic ok,
                            output logic [7:0] d0, output logic o0,
                            output logic [7:0] d1, output logic o1);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      if (out_valid0) ok = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    d0 = out_data0;
    o0 = out_ovf0;
    d1 = out_data1;
    o1 = out_ovf1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset_   = 1'b0;
    in_valid = 1'b1;
    in_data  = {4{8'hFF}};
    in_keep  = 4'hF;
    in_last  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (in_ready0 !== 1'b0) begin
      bad++; $display("FAIL rst_in_ready got %b want 0", in_ready0);
    end
    total++;
    if (out_valid0 !== 1'b0) begin
      bad++; $display("FAIL rst_out_valid got %b want 0", out_valid0);
    end
    total++;
    if (out_data0 !== 8'd0) begin
      bad++; $display("FAIL rst_out_data got %0d want 0", out_data0);
    end
    total++;
    if (out_ovf0 !== 1'b0) begin
      bad++; $display("FAIL rst_out_ovf got %b want 0", out_ovf0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    reset_   = 1'b1;
    #1;
    total++;
    if (in_ready0 !== 1'b1) begin
      bad++; $display("FAIL rst_release_ready got %b want 1", in_ready0);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid0 !== 1'b0) begin
      bad++; $display("FAIL rst_idle_valid got %b want 0", out_valid0);
    end
  endtask

  task automatic test_single;
    beat(8'd1, 8'd2, 8'd3, 8'd4, 4'hF, 1'b1);
    total++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      bad++;
      $display("FAIL single_flush got valid=%b ready=%b want 0 0",
               out_valid0, in_ready0);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid0 !== 1'b1) begin
      bad++; $display("FAIL single_latency got valid=%b want 1", out_valid0);
    end
    total++;
    if (out_data0 !== 8'd10) begin
      bad++; $display("FAIL single_data got %0d want 10", out_data0);
    end
    total++;
    if (out_ovf0 !== 1'b0) begin
      bad++; $display("FAIL single_ovf got %b want 0", out_ovf0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if (in_ready0 !== 1'b1 || out_valid0 !== 1'b0) begin
      bad++;
      $display("FAIL single_release got ready=%b valid=%b want 1 0",
               in_ready0, out_valid0);
    end
  endtask

  task automatic test_saturate;
    logic ok;
    logic [7:0] d0, d1;
    logic o0, o1;
    for (int b = 0; b < 3; b++) begin
      beat(8'd100, 8'd100, 8'd0, 8'd0, 4'hF, b == 2);
    end
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1) begin
      bad++; $display("FAIL sat_timeout got ok=%b want 1", ok);
    end
    total++;
    if (d0 !== 8'd127 || o0 !== 1'b1) begin
      bad++; $display("FAIL sat_600 got %0d ovf=%b want 127 ovf=1", d0, o0);
    end
    total++;
    if (d1 !== 8'h58 || o1 !== 1'b1) begin
      bad++; $display("FAIL wrap_600 got %0d ovf=%b want 88 ovf=1", d1, o1);
    end
  endtask

  task automatic test_negative;
    logic ok;
    logic [7:0] d0, d1;
    logic o0, o1;
    beat(8'h80, 8'h80, 8'd0, 8'd0, 4'hF, 1'b1);
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'h80 || o0 !== 1'b1) begin
      bad++;
      $display("FAIL neg_sat got ok=%b %h ovf=%b want 1 80 ovf=1",
               ok, d0, o0);
    end
    total++;
    if (d1 !== 8'h00 || o1 !== 1'b1) begin
      bad++; $display("FAIL neg_wrap got %h ovf=%b want 00 ovf=1", d1, o1);
    end
  endtask

  task automatic test_keep;
    logic ok;
    logic [7:0] d0, d1;
    logic o0, o1;
    beat(8'd10, 8'd20, 8'd30, 8'd40, 4'b0101, 1'b1);
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'd40 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL keep_mask got ok=%b %0d ovf=%b want 1 40 ovf=0",
               ok, d0, o0);
    end
  endtask

  task automatic test_hold;
    logic ok;
    logic [7:0] d0, d1;
    logic o0, o1;
    beat(8'd1, 8'd2, 8'd3, 8'd4, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = {4{8'd9}};
      in_keep  = 4'hF;
      in_last  = 1'b1;
      total++;
      if (out_valid0 !== 1'b1 || out_data0 !== 8'd10 ||
          in_ready0 !== 1'b0) begin
        bad++;
        $display("FAIL hold_c%0d got v=%b d=%0d r=%b want 1 10 0",
                 c, out_valid0, out_data0, in_ready0);
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++;
    if (in_ready0 !== 1'b1) begin
      bad++; $display("FAIL hold_release got ready=%b want 1", in_ready0);
    end
    beat(8'd7, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'd7 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL hold_ignored got ok=%b %0d ovf=%b want 1 7 ovf=0",
               ok, d0, o0);
    end
  endtask

  task automatic test_reset_mid;
    logic ok;
    logic [7:0] d0, d1;
    logic o0, o1;
    beat(8'd50, 8'd0, 8'd0, 8'd0, 4'hF, 1'b0);
    beat(8'd50, 8'd0, 8'd0, 8'd0, 4'hF, 1'b0);
    reset_ = 1'b0;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
    beat(8'd5, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'd5 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid got ok=%b %0d ovf=%b want 1 5 ovf=0",
               ok, d0, o0);
    end
    beat(8'd60, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
    @(posedge clk);
    #1;
    reset_ = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_done got valid=%b ready=%b want 0 0",
               out_valid0, in_ready0);
    end
    reset_ = 1'b1;
    beat(8'd3, 8'd0, 8'd0, 8'd0, 4'hF, 1'b1);
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'd3 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL rst_done_next got ok=%b %0d ovf=%b want 1 3 ovf=0",
               ok, d0, o0);
    end
  endtask

  task automatic test_maxbeat;
    logic ok;
    logic [7:0] d0, d1;
    logic o0, o1;
    for (int b = 0; b < 4; b++) begin
      beat(8'd1, 8'd0, 8'd0, 8'd0, 4'hF, b == 3);
    end
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'd4 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL beats4 got ok=%b %0d ovf=%b want 1 4 ovf=0",
               ok, d0, o0);
    end
    for (int b = 0; b < 5; b++) begin
      beat(8'd1, 8'd0, 8'd0, 8'd0, 4'hF, b == 4);
    end
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'd5 || o0 !== 1'b1) begin
      bad++;
      $display("FAIL beats5 got ok=%b %0d ovf=%b want 1 5 ovf=1",
               ok, d0, o0);
    end
  endtask

  task automatic test_back_to_back;
    logic ok;
    logic [7:0] d0, d1;
    logic o0, o1;
    for (int b = 0; b < 4; b++) begin
      beat(8'd9, 8'd9, 8'd9, 8'd9, 4'h0, 1'b0);
    end
    beat(8'd2, 8'd0, 8'd0, 8'd0, 4'h1, 1'b1);
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'd2 || o0 !== 1'b1) begin
      bad++;
      $display("FAIL keep0_count got ok=%b %0d ovf=%b want 1 2 ovf=1",
               ok, d0, o0);
    end
    beat(8'hFB, 8'hFE, 8'd1, 8'd0, 4'hF, 1'b0);
    beat(8'd0, 8'd0, 8'd0, 8'hFF, 4'hF, 1'b1);
    get_result(ok, d0, o0, d1, o1);
    total++;
    if (ok !== 1'b1 || d0 !== 8'hF9 || o0 !== 1'b0) begin
      bad++;
      $display("FAIL mixed_sign got ok=%b %h ovf=%b want 1 f9 ovf=0",
               ok, d0, o0);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset_    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_keep   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_saturate();
    test_negative();
    test_keep();
    test_hold();
    test_reset_mid();
    test_maxbeat();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
